// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_ctrl
// Purpose  : Stall/flush sequencer and next-PC select for the 5-stage pipeline.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_ctrl #(
    parameter int DIV_LATENCY = 32,
    parameter int CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             EX_load,
    input  logic [4:0]       EX_waddr,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_use_rs,
    input  logic             ID_use_rt,
    input  logic             EX_div_start,
    input  logic             MEM_redirect,
    input  logic             MEM_exc,
    input  logic             MEM_eret,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic [1:0]       pc_sel,
    output logic             epc_we,
    output logic             div_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        EXC_HOLD = 2'd2
    } state_t;

    localparam logic [5:0] C_DIV_LOAD = 6'(DIV_LATENCY - 2);

    state_t           state_q, state_d;
    logic [5:0]       div_count_q, div_count_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic w_load_use;
    logic w_pc_hold, w_ifid_hold, w_idex_hold;
    logic w_ifid_flush, w_idex_flush, w_exmem_flush, w_memwb_flush;
    logic [1:0] w_pc_sel;
    logic w_epc_we, w_div_busy;

    assign w_load_use = EX_load && (EX_waddr != 5'd0) &&
                        ((ID_use_rs && (ID_rs == EX_waddr)) ||
                         (ID_use_rt && (ID_rt == EX_waddr)));

    always_comb begin
        state_d       = state_q;
        div_count_d   = div_count_q;
        w_pc_hold     = 1'b0;
        w_ifid_hold   = 1'b0;
        w_idex_hold   = 1'b0;
        w_ifid_flush  = 1'b0;
        w_idex_flush  = 1'b0;
        w_exmem_flush = 1'b0;
        w_memwb_flush = 1'b0;
        w_pc_sel      = 2'd0;
        w_epc_we      = 1'b0;
        w_div_busy    = 1'b0;
        case (state_q)
            RUN: begin
                if (MEM_exc) begin
                    w_memwb_flush = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_pc_sel      = 2'd2;
                    w_epc_we      = 1'b1;
                    state_d       = EXC_HOLD;
                end else if (MEM_eret) begin
                    w_exmem_flush = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_pc_sel      = 2'd3;
                end else if (MEM_redirect) begin
                    w_exmem_flush = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_pc_sel      = 2'd1;
                end else if (EX_div_start) begin
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_idex_hold   = 1'b1;
                    w_exmem_flush = 1'b1;
                    div_count_d   = C_DIV_LOAD;
                    state_d       = DIV_WAIT;
                end else if (w_load_use) begin
                    w_pc_hold    = 1'b1;
                    w_ifid_hold  = 1'b1;
                    w_idex_flush = 1'b1;
                end
            end
            DIV_WAIT: begin
                // An older instruction faulting in MEM wins over the divide.
                if (MEM_exc) begin
                    w_memwb_flush = 1'b1;
                    w_exmem_flush = 1'b1;
                    w_idex_flush  = 1'b1;
                    w_ifid_flush  = 1'b1;
                    w_pc_sel      = 2'd2;
                    w_epc_we      = 1'b1;
                    div_count_d   = 6'd0;
                    state_d       = EXC_HOLD;
                end else begin
                    w_pc_hold     = 1'b1;
                    w_ifid_hold   = 1'b1;
                    w_idex_hold   = 1'b1;
                    w_div_busy    = 1'b1;
                    // Final cycle lets the quotient into EX/MEM.
                    w_exmem_flush = (div_count_q != 6'd0);
                    if (div_count_q == 6'd0) begin
                        state_d = RUN;
                    end else begin
                        div_count_d = div_count_q - 6'd1;
                    end
                end
            end
            EXC_HOLD: begin
                w_pc_hold     = 1'b1;
                w_ifid_hold   = 1'b1;
                w_idex_hold   = 1'b1;
                w_exmem_flush = 1'b1;
                state_d       = RUN;
            end
            default: begin
                state_d     = RUN;
                div_count_d = 6'd0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (w_pc_hold && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(negedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= RUN;
            div_count_q <= 6'd0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            div_count_q <= div_count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // A flush of a register always beats a hold of the same register.
    assign pc_hold     = w_pc_hold;
    assign ifid_hold   = w_ifid_hold & ~w_ifid_flush;
    assign idex_hold   = w_idex_hold & ~w_idex_flush;
    assign exmem_hold  = 1'b0;
    assign ifid_flush  = w_ifid_flush;
    assign idex_flush  = w_idex_flush;
    assign exmem_flush = w_exmem_flush;
    assign memwb_flush = w_memwb_flush;
    assign pc_sel      = w_pc_sel;
    assign epc_we      = w_epc_we;
    assign div_busy    = w_div_busy;
    assign stall_cnt   = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_ctrl
// Purpose  : Directed self-checking bench for pipeline_hazard_ctrl.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

    // {pc_hold,ifid_hold,idex_hold,exmem_hold, ifid_fl,idex_fl,exmem_fl,memwb_fl, pc_sel,epc_we,div_busy}
    localparam logic [11:0] C_IDLE    = 12'b0000_0000_0000;
    localparam logic [11:0] C_LOADUSE = 12'b1100_0100_0000;
    localparam logic [11:0] C_REDIR   = 12'b0000_1110_0100;
    localparam logic [11:0] C_ERET    = 12'b0000_1110_1100;
    localparam logic [11:0] C_EXC     = 12'b0000_1111_1010;
    localparam logic [11:0] C_DIVST   = 12'b1110_0010_0000;
    localparam logic [11:0] C_DIVWAIT = 12'b1110_0010_0001;
    localparam logic [11:0] C_DIVLAST = 12'b1110_0000_0001;
    localparam logic [11:0] C_EXCHOLD = 12'b1110_0010_0000;

    logic clock, reset;
    logic EX_load, ID_use_rs, ID_use_rt, EX_div_start, MEM_redirect, MEM_exc, MEM_eret;
    logic [4:0] EX_waddr, ID_rs, ID_rt;
    logic pc_hold, ifid_hold, idex_hold, exmem_hold;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush, epc_we, div_busy;
    logic [1:0] pc_sel;
    logic [15:0] stall_cnt;
    logic p4_pc_hold, p4_ifid_hold, p4_idex_hold, p4_exmem_hold;
    logic p4_ifid_flush, p4_idex_flush, p4_exmem_flush, p4_memwb_flush, p4_epc_we, p4_div_busy;
    logic [1:0] p4_pc_sel;
    logic [3:0] p4_stall_cnt;
    logic [11:0] ctl;

    int n_cmp = 0;
    int n_err = 0;
    int holds;

    assign ctl = {pc_hold, ifid_hold, idex_hold, exmem_hold,
                  ifid_flush, idex_flush, exmem_flush, memwb_flush,
                  pc_sel, epc_we, div_busy};

    pipeline_hazard_ctrl #(.DIV_LATENCY(32), .CNT_W(16)) dut (
        .clock(clock), .reset(reset),
        .EX_load(EX_load), .EX_waddr(EX_waddr), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .EX_div_start(EX_div_start),
        .MEM_redirect(MEM_redirect), .MEM_exc(MEM_exc), .MEM_eret(MEM_eret),
        .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_hold(idex_hold), .exmem_hold(exmem_hold),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .memwb_flush(memwb_flush), .pc_sel(pc_sel), .epc_we(epc_we), .div_busy(div_busy),
        .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.DIV_LATENCY(32), .CNT_W(4)) dut4 (
        .clock(clock), .reset(reset),
        .EX_load(EX_load), .EX_waddr(EX_waddr), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_use_rs(ID_use_rs), .ID_use_rt(ID_use_rt), .EX_div_start(EX_div_start),
        .MEM_redirect(MEM_redirect), .MEM_exc(MEM_exc), .MEM_eret(MEM_eret),
        .pc_hold(p4_pc_hold), .ifid_hold(p4_ifid_hold), .idex_hold(p4_idex_hold),
        .exmem_hold(p4_exmem_hold), .ifid_flush(p4_ifid_flush), .idex_flush(p4_idex_flush),
        .exmem_flush(p4_exmem_flush), .memwb_flush(p4_memwb_flush), .pc_sel(p4_pc_sel),
        .epc_we(p4_epc_we), .div_busy(p4_div_busy), .stall_cnt(p4_stall_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk_ctl(input string tag, input logic [11:0] exp);
        n_cmp++;
        assert (ctl === exp) else begin
            n_err++;
            $error("FAIL %s: observed ctl=%b expected ctl=%b", tag, ctl, exp);
        end
    endtask

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        EX_load = 1'b0; EX_waddr = 5'd0; ID_rs = 5'd0; ID_rt = 5'd0;
        ID_use_rs = 1'b0; ID_use_rt = 1'b0; EX_div_start = 1'b0;
        MEM_redirect = 1'b0; MEM_exc = 1'b0; MEM_eret = 1'b0;
    endtask

    // Advance to just after the next active (falling) edge.
    task automatic tick();
        @(negedge clock);
        #1;
    endtask

    task automatic load_use_rs3();
        EX_load = 1'b1; EX_waddr = 5'd3; ID_rs = 5'd3; ID_use_rs = 1'b1;
        ID_rt = 5'd5; ID_use_rt = 1'b1;
    endtask

    task automatic reset_pulse();
        #2 reset = 1'b0;
        #1 reset = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b0;
        clr();
        #12;
        chk_ctl("reset_ctl", C_IDLE);
        chk_val("reset_cnt", 32'(stall_cnt), 32'd0);
        reset = 1'b1;
        tick();

        // lw $3 in EX, add $4,$3,$5 in ID
        load_use_rs3();
        #2 chk_ctl("load_use", C_LOADUSE);
        tick();
        chk_val("load_use_cnt", 32'(stall_cnt), 32'd1);
        clr();

        EX_load = 1'b1; EX_waddr = 5'd0; ID_rs = 5'd0; ID_use_rs = 1'b1;
        #2 chk_ctl("waddr0_nostall", C_IDLE);
        tick();
        chk_val("waddr0_cnt", 32'(stall_cnt), 32'd1);
        clr();

        EX_load = 1'b1; EX_waddr = 5'd9; ID_rs = 5'd9; ID_use_rs = 1'b0;
        #2 chk_ctl("rs_unused_nostall", C_IDLE);
        tick();
        clr();

        load_use_rs3();
        MEM_redirect = 1'b1;
        #2 chk_ctl("redirect_over_lu", C_REDIR);
        tick();
        chk_val("redirect_cnt", 32'(stall_cnt), 32'd1);
        clr();

        // 19 more load-use stalls via rt: 20 in total
        for (int i = 0; i < 19; i++) begin
            EX_load = 1'b1; EX_waddr = 5'd7; ID_rt = 5'd7; ID_use_rt = 1'b1;
            tick();
        end
        clr();
        chk_val("cnt16_20", 32'(stall_cnt), 32'd20);
        chk_val("cnt4_sat", 32'(p4_stall_cnt), 32'd15);

        reset_pulse();
        chk_val("cnt_after_reset", 32'(stall_cnt), 32'd0);

        // Divide: 1 RUN cycle + 31 DIV_WAIT cycles
        EX_div_start = 1'b1;
        #2 chk_ctl("div_start", C_DIVST);
        holds = 1;
        tick();
        clr();
        for (int i = 0; i < 31; i++) begin
            #2 chk_ctl($sformatf("div_wait_%0d", i), (i == 30) ? C_DIVLAST : C_DIVWAIT);
            if (pc_hold) holds++;
            tick();
        end
        #2 chk_ctl("div_done_run", C_IDLE);
        chk_val("div_hold_cycles", 32'(holds), 32'd32);
        chk_val("div_cnt", 32'(stall_cnt), 32'd32);
        tick();

        MEM_eret = 1'b1;
        #2 chk_ctl("eret", C_ERET);
        tick();
        MEM_exc = 1'b1;
        #2 chk_ctl("exc_and_eret", C_EXC);
        tick();
        clr();
        #2 chk_ctl("exc_hold", C_EXCHOLD);
        tick();
        #2 chk_ctl("exc_back_run", C_IDLE);
        tick();

        // Exception at the fifth cycle of the divide
        EX_div_start = 1'b1;
        tick();
        clr();
        for (int i = 0; i < 3; i++) tick();
        MEM_exc = 1'b1;
        #2 chk_ctl("div_exc", C_EXC);
        tick();
        clr();
        #2 chk_ctl("div_exc_hold", C_EXCHOLD);
        tick();
        #2 chk_ctl("div_exc_run", C_IDLE);
        tick();

        // Asynchronous reset in DIV_WAIT
        reset_pulse();
        EX_div_start = 1'b1;
        tick();
        clr();
        tick();
        #2 chk_ctl("pre_reset_divwait", C_DIVWAIT);
        reset = 1'b0;
        #1 chk_ctl("async_reset_ctl", C_IDLE);
        chk_val("async_reset_cnt", 32'(stall_cnt), 32'd0);
        #1 reset = 1'b1;
        tick();
        #2 chk_ctl("after_reset_run", C_IDLE);
        tick();
        chk_val("after_reset_cnt", 32'(stall_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
